cla_adder5: RTL and testbench
=============================

# cla_adder5

Registered 5-bit carry look-ahead adder: computes `a + b + cin` with explicitly generated look-ahead carries rather than a ripple chain. The sum and carry-out are captured in an output register. It is a leaf arithmetic datapath block intended for ALU and accumulator paths that need a fast, deterministic 1-cycle add.

## Interface
Parameters:
- `WIDTH`, default 5: operand width. Legal range 1–16. All tests use 5.
- `GROUP`, default 4: bits per look-ahead group. The last group is partial when `WIDTH % GROUP != 0`.

Ports:
- `clk`, input, 1: the single clock. Rising-edge active.
- `rst`, input, 1: reset, asynchronous and active-high.
- `a`, input, WIDTH: operand A, unsigned.
- `b`, input, WIDTH: operand B, unsigned.
- `cin`, input, 1: carry-in.
- `s`, output, WIDTH: registered sum bits.
- `cout`, output, 1: registered carry-out of the MSB.

## Operation
- Per bit i:
  - generate `g[i] = a[i] & b[i]`
  - propagate `p[i] = a[i] ^ b[i]`
- Carries are computed in look-ahead form. There is no ripple between bits inside a group.
  - `c[0] = cin`
  - `c[i+1] = g[i] | p[i]&g[i-1] | … | p[i]&…&p[0]&cin`, expanded within each group.
- Each group exports a group generate `G` and group propagate `P`. The group carry-out is `G | P&c_in_group`, which chains group to group.
- Sum bit: `s_next[i] = p[i] ^ c[i]`.
- Carry-out: `cout_next = c[WIDTH]`.
- `{cout_next, s_next}` must equal `a + b + cin` computed in WIDTH+1 bits for all inputs. It wraps modulo 2^WIDTH, with overflow reported only via `cout`.
- Operands are unsigned. There is no signed overflow flag.
- There is no handshake. A new operation is accepted every cycle.

## Timing
- Latency is 1 cycle. Inputs are sampled at rising edge N, and `s`/`cout` reflect them after edge N, until edge N+1.
- Throughput is one add per clock.
- Reset:
  - When `rst` is asserted, `s` becomes all zeros and `cout` becomes 0 immediately, with no clock edge required.
  - Outputs stay at zero while `rst` is high.
  - The first operand set is captured on the first rising edge after `rst` deasserts.
- Reset asserted mid-stream drops the in-flight result. There is no recovery of it.
- Inputs changing between edges have no effect on the outputs.
- The combinational path from `a`/`b`/`cin` to the register D input must contain no ripple chain longer than one group.

## Structure
- No shared package is needed. `WIDTH` and `GROUP` are module parameters only.
- There is one natural sub-module: `cla_group`.
  - Parameterized width (≤ `GROUP`).
  - Inputs: `g`, `p`, `ci`.
  - Outputs: internal carries, group `G`, group `P`.
- The top level instantiates `ceil(WIDTH/GROUP)` `cla_group` instances via generate, chains their group carries, forms the sums, and holds the output register.

## Test plan
- `a=5'b01100`, `b=5'b10011`, `cin=0` -> after 1 clk: `s=5'b11111`, `cout=0`.
- Same a/b with `cin=1` -> `s=5'b00000`, `cout=1` (full carry propagation across all bits).
- `a=5'b01001`, `b=5'b11011`, `cin=1` -> `s=5'b00101`, `cout=1`.
- Reset:
  - Apply `a=31`, `b=31`, `cin=1` and clock once, giving `s=31`, `cout=1`.
  - Then assert `rst` between edges -> `s=0`, `cout=0` immediately.
  - After release, the next edge shows the new result.
- Back-to-back inputs on consecutive edges -> each result appears exactly one cycle later, with no skipped or duplicated results.
- Exhaustive: all 2^11 combinations of `a`, `b`, `cin` (WIDTH=5) -> `{cout,s}` matches `a+b+cin` one cycle later. Repeat with `WIDTH=8`, `GROUP=4` on random vectors.

Source files
------------

// File: rtl/cla_adder5_pkg.sv
// Shared sizing helpers for the registered carry look-ahead adder.
package cla_adder5_pkg;

    function automatic int unsigned num_groups(input int unsigned width, input int unsigned grp);
        return (width + grp - 1) / grp;
    endfunction

    // Width of group k; the last group is partial when grp does not divide width.
    function automatic int unsigned grp_width(input int unsigned width, input int unsigned grp,
                                              input int unsigned k);
        int unsigned lo;
        lo = k * grp;
        return ((width - lo) < grp) ? (width - lo) : grp;
    endfunction

endpackage

// File: rtl/cla_adder5_group.sv
// One look-ahead group: flat sum-of-products carries plus group generate/propagate.
module cla_group #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] g,
    input  logic [W-1:0] p,
    input  logic         ci,
    output logic [W-1:0] c,
    output logic         gg,
    output logic         gp
);

    // Every carry is an independent two-level OR of AND terms, so no carry waits on another.
    always_comb begin
        logic cv;
        logic term;
        c = '0;
        for (int i = 0; i < W; i++) begin
            cv = ci;
            for (int k = 0; k < i; k++) cv = cv & p[k];
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) term = term & p[k];
                cv = cv | term;
            end
            c[i] = cv;
        end
    end

    always_comb begin
        logic term;
        gg = 1'b0;
        gp = &p;
        for (int j = 0; j < W; j++) begin
            term = g[j];
            for (int k = j + 1; k < W; k++) term = term & p[k];
            gg = gg | term;
        end
    end

endmodule

// File: rtl/cla_adder5.sv
// Registered unsigned adder: {cout, s} <= a + b + cin using chained look-ahead groups.
module cla_adder5
    import cla_adder5_pkg::*;
#(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int unsigned NGroups = num_groups(WIDTH, GROUP);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] sum_w;
    logic             carry_w;
    logic [WIDTH-1:0] s_d, s_q;
    logic             cout_d, cout_q;

    assign g = a & b;
    assign p = a ^ b;

    for (genvar k = 0; k < NGroups; k++) begin : g_grp
        localparam int unsigned Lo = k * GROUP;
        localparam int unsigned W  = grp_width(WIDTH, GROUP, k);

        logic [W-1:0] cg;
        logic         ci;
        logic         gg;
        logic         gp;
        logic         co;

        if (k == 0) begin : g_first
            assign ci = cin;
        end else begin : g_chain
            assign ci = g_grp[k-1].co;
        end

        cla_group #(
            .W (W)
        ) u_grp (
            .g  (g[Lo +: W]),
            .p  (p[Lo +: W]),
            .ci (ci),
            .c  (cg),
            .gg (gg),
            .gp (gp)
        );

        assign co            = gg | (gp & ci);
        assign sum_w[Lo +: W] = p[Lo +: W] ^ cg;
    end

    assign carry_w = g_grp[NGroups-1].co;

    always_comb begin
        s_d    = sum_w;
        cout_d = carry_w;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_cla_adder5.sv
// Directed and exhaustive checks of the registered look-ahead adder (5-bit and 8-bit).
module tb_cla_adder5;

    logic       clk;
    logic       rst;
    logic [4:0] a, b;
    logic       cin;
    logic [4:0] s;
    logic       cout;
    logic [7:0] a8, b8;
    logic       cin8;
    logic [7:0] s8;
    logic       cout8;

    int checks;
    int errors;

    cla_adder5 #(.WIDTH(5), .GROUP(4)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .s    (s),
        .cout (cout)
    );

    cla_adder5 #(.WIDTH(8), .GROUP(4)) u_dut8 (
        .clk  (clk),
        .rst  (rst),
        .a    (a8),
        .b    (b8),
        .cin  (cin8),
        .s    (s8),
        .cout (cout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive at the falling edge, capture on the rising edge, sample 1 time unit later.
    task automatic apply(input logic [4:0] va, input logic [4:0] vb, input logic vc);
        @(negedge clk);
        a   = va;
        b   = vb;
        cin = vc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a = 5'd7; b = 5'd9; cin = 1'b1;
        a8 = 8'd0; b8 = 8'd0; cin8 = 1'b0;
        #1;
        checks++;
        if ({cout, s} !== 6'd0) begin
            errors++;
            $display("FAIL reset_async: got %b_%b expected 0_00000", cout, s);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({cout, s} !== 6'd0) begin
            errors++;
            $display("FAIL reset_hold: got %b_%b expected 0_00000", cout, s);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        apply(5'b01100, 5'b10011, 1'b0);
        checks++;
        if (s !== 5'b11111 || cout !== 1'b0) begin
            errors++;
            $display("FAIL vec_no_carry: got %b_%b expected 0_11111", cout, s);
        end
        apply(5'b01100, 5'b10011, 1'b1);
        checks++;
        if (s !== 5'b00000 || cout !== 1'b1) begin
            errors++;
            $display("FAIL vec_full_prop: got %b_%b expected 1_00000", cout, s);
        end
        apply(5'b01001, 5'b11011, 1'b1);
        checks++;
        if (s !== 5'b00101 || cout !== 1'b1) begin
            errors++;
            $display("FAIL vec_mixed: got %b_%b expected 1_00101", cout, s);
        end
    endtask

    task automatic test_reset_midstream();
        apply(5'd31, 5'd31, 1'b1);
        checks++;
        if (s !== 5'd31 || cout !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got %b_%b expected 1_11111", cout, s);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({cout, s} !== 6'd0) begin
            errors++;
            $display("FAIL mid_reset_async: got %b_%b expected 0_00000", cout, s);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({cout, s} !== 6'd0) begin
            errors++;
            $display("FAIL mid_reset_hold: got %b_%b expected 0_00000", cout, s);
        end
        @(negedge clk);
        rst = 1'b0;
        a = 5'd3; b = 5'd4; cin = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (s !== 5'd7 || cout !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got %b_%b expected 0_00111", cout, s);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] ta [6];
        logic [4:0] tb [6];
        logic       tc [6];
        logic [5:0] te [6];
        ta = '{5'd1, 5'd16, 5'd31, 5'd0, 5'd10, 5'd21};
        tb = '{5'd2, 5'd16, 5'd0,  5'd0, 5'd5,  5'd10};
        tc = '{1'b0, 1'b0,  1'b1,  1'b1, 1'b0,  1'b1};
        te = '{6'd3, 6'd32, 6'd32, 6'd1, 6'd15, 6'd32};
        for (int i = 0; i < 6; i++) begin
            apply(ta[i], tb[i], tc[i]);
            checks++;
            if ({cout, s} !== te[i]) begin
                errors++;
                $display("FAIL b2b_%0d: got %0d expected %0d", i, {cout, s}, te[i]);
            end
            // Inputs moving between edges must not disturb the held result.
            a = ~ta[i];
            b = 5'd13;
            cin = ~tc[i];
            #2;
            checks++;
            if ({cout, s} !== te[i]) begin
                errors++;
                $display("FAIL b2b_hold_%0d: got %0d expected %0d", i, {cout, s}, te[i]);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [5:0] exp;
        int         bad;
        bad = 0;
        for (int i = 0; i < 2048; i++) begin
            apply(i[4:0], i[9:5], i[10]);
            exp = {1'b0, i[4:0]} + {1'b0, i[9:5]} + {5'd0, i[10]};
            checks++;
            if ({cout, s} !== exp) begin
                errors++;
                bad++;
                if (bad <= 8)
                    $display("FAIL exh a=%0d b=%0d cin=%0d: got %0d expected %0d",
                             i[4:0], i[9:5], i[10], {cout, s}, exp);
            end
        end
    endtask

    task automatic test_width8();
        logic [8:0] exp;
        logic [7:0] va, vb;
        logic       vc;
        for (int i = 0; i < 40; i++) begin
            va = 8'($urandom_range(0, 255));
            vb = 8'($urandom_range(0, 255));
            vc = 1'($urandom_range(0, 1));
            if (i == 0) begin
                va = 8'hff; vb = 8'h00; vc = 1'b1;
            end
            @(negedge clk);
            a8 = va; b8 = vb; cin8 = vc;
            @(posedge clk);
            #1;
            exp = {1'b0, va} + {1'b0, vb} + {8'd0, vc};
            checks++;
            if ({cout8, s8} !== exp) begin
                errors++;
                $display("FAIL w8 a=%0d b=%0d cin=%0d: got %0d expected %0d",
                         va, vb, vc, {cout8, s8}, exp);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_vectors();
        test_reset_midstream();
        test_back_to_back();
        test_exhaustive();
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
